// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_pkg
//  Description : Shared types and constants for the ECC scalar-multiplication
//                sequencer, the shared point-operation unit and the
//                key-exchange core.
//                  MAX_BITS - default scalar/coordinate/prime width
//                  OP_DBL   - point-op code for DOUBLE(A)
//                  OP_ADD   - point-op code for ADD(A,B)
//                  state_t  - sequencer state encoding
//                  point_t  - affine point with explicit infinity flag
//  Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int MAX_BITS = 256;

    localparam logic OP_DBL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        DBL  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Coordinates are meaningless when inf is set.
    typedef struct packed {
        logic [MAX_BITS-1:0] x;
        logic [MAX_BITS-1:0] y;
        logic                inf;
    } point_t;

endpackage
`default_nettype wire

// File: rtl/ecc_scalar_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scalar_mul_ctrl_if
//  Description : Request/done handshake between the scalar-multiplication
//                sequencer (master) and the shared point-operation unit
//                (slave). Signal prefixes are from the sequencer's viewpoint.
//                  o_op_req                 - operation request (level)
//                  o_op_code                - OP_DBL / OP_ADD
//                  o_op_ax/ay, o_op_bx/by   - operands A and B
//                  o_op_prime               - field prime
//                  i_op_done                - completion pulse
//                  i_op_rx/ry, i_op_inf     - operation result
//  Revision    : 1.0 - initial release
// ============================================================================
interface ecc_scalar_mul_ctrl_if #(
    parameter int MAX_BITS = 256
);

    logic                o_op_req;
    logic                o_op_code;
    logic [MAX_BITS-1:0] o_op_ax;
    logic [MAX_BITS-1:0] o_op_ay;
    logic [MAX_BITS-1:0] o_op_bx;
    logic [MAX_BITS-1:0] o_op_by;
    logic [MAX_BITS-1:0] o_op_prime;
    logic                i_op_done;
    logic [MAX_BITS-1:0] i_op_rx;
    logic [MAX_BITS-1:0] i_op_ry;
    logic                i_op_inf;

    // Sequencer side
    modport master (
        output o_op_req,
        output o_op_code,
        output o_op_ax,
        output o_op_ay,
        output o_op_bx,
        output o_op_by,
        output o_op_prime,
        input  i_op_done,
        input  i_op_rx,
        input  i_op_ry,
        input  i_op_inf
    );

    // Point-operation unit side
    modport slave (
        input  o_op_req,
        input  o_op_code,
        input  o_op_ax,
        input  o_op_ay,
        input  o_op_bx,
        input  o_op_by,
        input  o_op_prime,
        output i_op_done,
        output i_op_rx,
        output i_op_ry,
        output i_op_inf
    );

endinterface
`default_nettype wire

// File: rtl/ecc_scalar_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scalar_mul_ctrl
//  Description : Sequencer for R = k*P over GF(p) using MSB-first
//                double-and-add. DOUBLE/ADD operations are issued to an
//                external shared point-operation unit; every point-at-
//                infinity case is resolved locally.
//
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_start         - start pulse (only honoured in IDLE)
//                i_scalar        - scalar k
//                i_px, i_py      - affine base point P (never infinity)
//                i_prime         - field prime
//                o_busy          - high from the cycle after start until
//                                  the DONE cycle ends
//                o_done          - one-cycle result-valid pulse
//                o_rx, o_ry      - result coordinates (held)
//                o_inf           - result is the point at infinity
//                op_bus          - point-op handshake (master modport)
//
//  Options     : ECC_SMUL_CONST_TIME_EN - when defined, every DBL with a
//                non-infinity result is followed by an ADD; the ADD result
//                is only kept for set scalar bits, so the op count depends
//                only on the position of the leading one.
//  Revision    : 1.0 - initial release
// ============================================================================
import ecc_pkg::*;

module ecc_scalar_mul_ctrl #(
    parameter int MAX_BITS = 256,
    parameter int IDX_W    = $clog2(MAX_BITS)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_start,
    input  wire logic [MAX_BITS-1:0] i_scalar,
    input  wire logic [MAX_BITS-1:0] i_px,
    input  wire logic [MAX_BITS-1:0] i_py,
    input  wire logic [MAX_BITS-1:0] i_prime,
    output logic                     o_busy,
    output logic                     o_done,
    output logic      [MAX_BITS-1:0] o_rx,
    output logic      [MAX_BITS-1:0] o_ry,
    output logic                     o_inf,
    ecc_scalar_mul_ctrl_if.master    op_bus
);

    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(MAX_BITS - 1);

    // ------------------------------------------------------------------
    // State and latched operands
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [MAX_BITS-1:0] r_k;
    logic [MAX_BITS-1:0] r_px;
    logic [MAX_BITS-1:0] r_py;
    logic [MAX_BITS-1:0] r_prime;

    // Accumulator point R
    logic [MAX_BITS-1:0] r_acc_x;
    logic [MAX_BITS-1:0] r_acc_y;
    logic                r_acc_inf;

    // ------------------------------------------------------------------
    // Next-accumulator and transition decisions
    // ------------------------------------------------------------------
    logic                w_bit;
    logic                w_last;
    logic                w_op_fire;
    logic [MAX_BITS-1:0] w_acc_x;
    logic [MAX_BITS-1:0] w_acc_y;
    logic                w_acc_inf;
    logic                w_step;
    logic                w_to_dbl;
    logic                w_to_add;

    assign w_bit     = r_k[r_idx];
    assign w_last    = (r_idx == '0);
    // A done pulse only counts while a request is actually outstanding.
    assign w_op_fire = op_bus.o_op_req & op_bus.i_op_done;

    always_comb begin
        w_acc_x   = r_acc_x;
        w_acc_y   = r_acc_y;
        w_acc_inf = r_acc_inf;
        w_step    = 1'b0;
        w_to_dbl  = 1'b0;
        w_to_add  = 1'b0;

        case (r_state)
            EVAL: begin
                if (r_acc_inf) begin
                    // 2*inf = inf and inf + P = P: no op needed.
                    if (w_bit) begin
                        w_acc_x   = r_px;
                        w_acc_y   = r_py;
                        w_acc_inf = 1'b0;
                    end
                    w_step = 1'b1;
                end else begin
                    w_to_dbl = 1'b1;
                end
            end

            DBL: begin
                if (w_op_fire) begin
                    w_acc_x   = op_bus.i_op_rx;
                    w_acc_y   = op_bus.i_op_ry;
                    w_acc_inf = op_bus.i_op_inf;
`ifdef ECC_SMUL_CONST_TIME_EN
                    if (op_bus.i_op_inf) begin
                        if (w_bit) begin
                            w_acc_x   = r_px;
                            w_acc_y   = r_py;
                            w_acc_inf = 1'b0;
                        end
                        w_step = 1'b1;
                    end else begin
                        w_to_add = 1'b1;
                    end
`else
                    if (w_bit) begin
                        // inf + P resolved locally instead of issuing ADD.
                        if (op_bus.i_op_inf) begin
                            w_acc_x   = r_px;
                            w_acc_y   = r_py;
                            w_acc_inf = 1'b0;
                            w_step    = 1'b1;
                        end else begin
                            w_to_add = 1'b1;
                        end
                    end else begin
                        w_step = 1'b1;
                    end
`endif
                end
            end

            ADD: begin
                if (w_op_fire) begin
`ifdef ECC_SMUL_CONST_TIME_EN
                    // Dummy ADD for clear bits: R keeps the DBL result.
                    if (w_bit) begin
                        w_acc_x   = op_bus.i_op_rx;
                        w_acc_y   = op_bus.i_op_ry;
                        w_acc_inf = op_bus.i_op_inf;
                    end
`else
                    w_acc_x   = op_bus.i_op_rx;
                    w_acc_y   = op_bus.i_op_ry;
                    w_acc_inf = op_bus.i_op_inf;
`endif
                    w_step = 1'b1;
                end
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_idx             <= '0;
            r_k               <= '0;
            r_px              <= '0;
            r_py              <= '0;
            r_prime           <= '0;
            r_acc_x           <= '0;
            r_acc_y           <= '0;
            r_acc_inf         <= 1'b1;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_rx              <= '0;
            o_ry              <= '0;
            o_inf             <= 1'b0;
            op_bus.o_op_req   <= 1'b0;
            op_bus.o_op_code  <= OP_DBL;
            op_bus.o_op_ax    <= '0;
            op_bus.o_op_ay    <= '0;
            op_bus.o_op_bx    <= '0;
            op_bus.o_op_by    <= '0;
            op_bus.o_op_prime <= '0;
        end else begin
            o_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_k       <= i_scalar;
                        r_px      <= i_px;
                        r_py      <= i_py;
                        r_prime   <= i_prime;
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_acc_inf <= 1'b1;
                        r_idx     <= c_idx_top;
                        o_busy    <= 1'b1;
                        r_state   <= EVAL;
                    end
                end

                EVAL, DBL, ADD: begin
                    r_acc_x   <= w_acc_x;
                    r_acc_y   <= w_acc_y;
                    r_acc_inf <= w_acc_inf;

                    // First cycle in DBL/ADD: launch the request. Operands
                    // are frozen until the matching done is sampled.
                    if ((r_state != EVAL) && !op_bus.o_op_req) begin
                        op_bus.o_op_req   <= 1'b1;
                        op_bus.o_op_code  <= (r_state == ADD) ? OP_ADD : OP_DBL;
                        op_bus.o_op_ax    <= r_acc_x;
                        op_bus.o_op_ay    <= r_acc_y;
                        op_bus.o_op_bx    <= r_px;
                        op_bus.o_op_by    <= r_py;
                        op_bus.o_op_prime <= r_prime;
                    end

                    if (w_op_fire) begin
                        op_bus.o_op_req <= 1'b0;
                    end

                    if (w_to_dbl) begin
                        r_state <= DBL;
                    end else if (w_to_add) begin
                        r_state <= ADD;
                    end else if (w_step) begin
                        if (w_last) begin
                            r_state <= DONE;
                            o_done  <= 1'b1;
                            o_rx    <= w_acc_x;
                            o_ry    <= w_acc_y;
                            o_inf   <= w_acc_inf;
                        end else begin
                            r_idx   <= r_idx - IDX_W'(1);
                            r_state <= EVAL;
                        end
                    end
                end

                DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_scalar_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_scalar_mul_ctrl
//  Description : Directed self-checking bench for ecc_scalar_mul_ctrl.
//                A behavioural point-op unit on y^2 = x^3 + 2x + 2 mod 17
//                answers requests after a random 1..20 cycle delay.
//                Base point P = (5,1), group order 19.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ecc_scalar_mul_ctrl;

    localparam int MB = 256;
    localparam int PR = 17;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          i_start  = 1'b0;
    logic [MB-1:0] i_scalar = '0;
    logic [MB-1:0] i_px     = '0;
    logic [MB-1:0] i_py     = '0;
    logic [MB-1:0] i_prime  = '0;
    logic          o_busy;
    logic          o_done;
    logic [MB-1:0] o_rx;
    logic [MB-1:0] o_ry;
    logic          o_inf;

    ecc_scalar_mul_ctrl_if #(.MAX_BITS(MB)) bus ();

    ecc_scalar_mul_ctrl #(.MAX_BITS(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_scalar (i_scalar),
        .i_px     (i_px),
        .i_py     (i_py),
        .i_prime  (i_prime),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_rx     (o_rx),
        .o_ry     (o_ry),
        .o_inf    (o_inf),
        .op_bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural point-op unit
    // ------------------------------------------------------------------
    logic          resp_done   = 1'b0;
    logic          manual_done = 1'b0;
    logic [MB-1:0] resp_rx     = '0;
    logic [MB-1:0] resp_ry     = '0;
    logic          resp_inf    = 1'b0;

    assign bus.i_op_done = resp_done | manual_done;
    assign bus.i_op_rx   = resp_rx;
    assign bus.i_op_ry   = resp_ry;
    assign bus.i_op_inf  = resp_inf;

    function automatic int md(input int v);
        return ((v % PR) + PR) % PR;
    endfunction

    function automatic int inv(input int a);
        int r = 1;
        for (int i = 0; i < PR - 2; i++) r = md(r * a);
        return r;
    endfunction

    task automatic pt_dbl(input int x, input int y, input bit inf,
                          output int rx, output int ry, output bit rinf);
        int l;
        if (inf || md(y) == 0) begin
            rx = 0; ry = 0; rinf = 1'b1;
        end else begin
            l    = md(md(3 * x * x + 2) * inv(md(2 * y)));
            rx   = md(l * l - 2 * x);
            ry   = md(l * (x - rx) - y);
            rinf = 1'b0;
        end
    endtask

    task automatic pt_add(input int x1, input int y1, input bit i1,
                          input int x2, input int y2, input bit i2,
                          output int rx, output int ry, output bit rinf);
        int l;
        if (i1) begin
            rx = x2; ry = y2; rinf = i2;
        end else if (i2) begin
            rx = x1; ry = y1; rinf = 1'b0;
        end else if (x1 == x2) begin
            if (md(y1 + y2) == 0) begin
                rx = 0; ry = 0; rinf = 1'b1;
            end else begin
                pt_dbl(x1, y1, 1'b0, rx, ry, rinf);
            end
        end else begin
            l    = md(md(y2 - y1) * inv(md(x2 - x1)));
            rx   = md(l * l - x1 - x2);
            ry   = md(l * (x1 - rx) - y1);
            rinf = 1'b0;
        end
    endtask

    int            op_count = 0;
    logic [15:0]   op_seq   = '0;

    initial begin : responder
        bit            pending = 1'b0;
        int            delay   = 0;
        logic          l_code  = 1'b0;
        logic [MB-1:0] l_ax = '0, l_ay = '0, l_bx = '0, l_by = '0, l_pr = '0;
        int            rx, ry;
        bit            rinf;
        forever begin
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                check("op_req_held",  MB'(bus.o_op_req), MB'(1));
                check("op_code_held", MB'(bus.o_op_code), MB'(l_code));
                check("op_ax_held",   bus.o_op_ax, l_ax);
                check("op_ay_held",   bus.o_op_ay, l_ay);
                check("op_bx_held",   bus.o_op_bx, l_bx);
                check("op_by_held",   bus.o_op_by, l_by);
                check("op_pr_held",   bus.o_op_prime, l_pr);
                delay--;
                if (delay == 0) begin
                    if (l_code == 1'b0)
                        pt_dbl(int'(l_ax[7:0]), int'(l_ay[7:0]), 1'b0, rx, ry, rinf);
                    else
                        pt_add(int'(l_ax[7:0]), int'(l_ay[7:0]), 1'b0,
                               int'(l_bx[7:0]), int'(l_by[7:0]), 1'b0, rx, ry, rinf);
                    resp_rx   = MB'(rx);
                    resp_ry   = MB'(ry);
                    resp_inf  = rinf;
                    resp_done = 1'b1;
                    pending   = 1'b0;
                end
            end else if (bus.o_op_req) begin
                pending  = 1'b1;
                delay    = int'($urandom_range(1, 20));
                l_code   = bus.o_op_code;
                l_ax     = bus.o_op_ax;
                l_ay     = bus.o_op_ay;
                l_bx     = bus.o_op_bx;
                l_by     = bus.o_op_by;
                l_pr     = bus.o_op_prime;
                op_count = op_count + 1;
                op_seq   = {op_seq[14:0], bus.o_op_code};
                check("op_prime", bus.o_op_prime, MB'(17));
                if (bus.o_op_code == 1'b1) begin
                    check("op_add_bx", bus.o_op_bx, MB'(5));
                    check("op_add_by", bus.o_op_by, MB'(1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic start_run(input int k);
        @(negedge clk);
        i_scalar = MB'(k);
        i_px     = MB'(5);
        i_py     = MB'(1);
        i_prime  = MB'(17);
        i_start  = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
    endtask

    // Called on the negedge of the first cycle after the start cycle.
    task automatic wait_done(input int limit, output int n, output bit ok);
        n  = 1;
        ok = 1'b0;
        while (n <= limit) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int n;
        bit ok;
        int base;
        int w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", MB'(o_busy), MB'(0));
        check("rst_done", MB'(o_done), MB'(0));
        check("rst_req",  MB'(bus.o_op_req), MB'(0));
        check("rst_rx",   o_rx, MB'(0));
        check("rst_ry",   o_ry, MB'(0));
        check("rst_inf",  MB'(o_inf), MB'(0));
        rst = 1'b0;

        // k = 0: MAX_BITS EVAL cycles, done in cycle MAX_BITS+1, no ops
        base = op_count;
        start_run(0);
        check("k0_busy_early", MB'(o_busy), MB'(1));
        wait_done(2000, n, ok);
        check("k0_done_seen", MB'(ok), MB'(1));
        check("k0_latency",   MB'(n), MB'(MB + 1));
        check("k0_inf",       MB'(o_inf), MB'(1));
        check("k0_ops",       MB'(op_count - base), MB'(0));
        @(negedge clk);
        check("k0_done_pulse", MB'(o_done), MB'(0));
        check("k0_busy_end",   MB'(o_busy), MB'(0));

        // Stray done pulse while idle
        base = op_count;
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done_busy", MB'(o_busy), MB'(0));
        check("idle_done_req",  MB'(bus.o_op_req), MB'(0));
        check("idle_done_out",  MB'(o_done), MB'(0));
        check("idle_done_ops",  MB'(op_count - base), MB'(0));

        // k = 1 -> P, no ops
        base = op_count;
        start_run(1);
        wait_done(2000, n, ok);
        check("k1_done_seen", MB'(ok), MB'(1));
        check("k1_rx",  o_rx, MB'(5));
        check("k1_ry",  o_ry, MB'(1));
        check("k1_inf", MB'(o_inf), MB'(0));
        check("k1_ops", MB'(op_count - base), MB'(0));

        // k = 9 with a start pulse and input changes while busy -> 9P = (7,6)
        base = op_count;
        start_run(9);
        repeat (20) @(negedge clk);
        i_scalar = MB'(2);
        i_px     = MB'(6);
        i_py     = MB'(3);
        i_start  = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
        // Keep a second stray start near the op phase as well
        w = 0;
        while (!bus.o_op_req && w < 1000) begin
            @(negedge clk);
            w++;
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(5000, n, ok);
        check("k9_done_seen", MB'(ok), MB'(1));
        check("k9_rx",  o_rx, MB'(7));
        check("k9_ry",  o_ry, MB'(6));
        check("k9_inf", MB'(o_inf), MB'(0));
`ifdef ECC_SMUL_CONST_TIME_EN
        check("k9_ops", MB'(op_count - base), MB'(6));
        check("k9_seq", MB'(op_seq[5:0]), MB'(6'b010101));
`else
        check("k9_ops", MB'(op_count - base), MB'(4));
        check("k9_seq", MB'(op_seq[3:0]), MB'(4'b0001));
`endif
        @(negedge clk);
        check("k9_busy_end", MB'(o_busy), MB'(0));

        // k = 19 (group order) -> infinity
        base = op_count;
        start_run(19);
        wait_done(5000, n, ok);
        check("k19_done_seen", MB'(ok), MB'(1));
        check("k19_inf", MB'(o_inf), MB'(1));
`ifdef ECC_SMUL_CONST_TIME_EN
        check("k19_ops", MB'(op_count - base), MB'(8));
        check("k19_seq", MB'(op_seq[7:0]), MB'(8'b01010101));
`else
        check("k19_ops", MB'(op_count - base), MB'(6));
        check("k19_seq", MB'(op_seq[5:0]), MB'(6'b000101));
`endif

        // Reset during the first DBL wait
        start_run(9);
        w = 0;
        while (!bus.o_op_req && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("rstmid_req_seen", MB'(bus.o_op_req), MB'(1));
        check("rstmid_code",     MB'(bus.o_op_code), MB'(0));
        rst = 1'b1;
        #1;
        check("rstmid_req_drop",  MB'(bus.o_op_req), MB'(0));
        check("rstmid_busy_drop", MB'(o_busy), MB'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_late_busy", MB'(o_busy), MB'(0));
        check("rstmid_late_req",  MB'(bus.o_op_req), MB'(0));
        check("rstmid_late_done", MB'(o_done), MB'(0));

        // k = 2 after the reset -> 2P = (6,3)
        base = op_count;
        start_run(2);
        wait_done(5000, n, ok);
        check("k2_done_seen", MB'(ok), MB'(1));
        check("k2_rx",  o_rx, MB'(6));
        check("k2_ry",  o_ry, MB'(3));
        check("k2_inf", MB'(o_inf), MB'(0));
`ifdef ECC_SMUL_CONST_TIME_EN
        check("k2_ops", MB'(op_count - base), MB'(2));
`else
        check("k2_ops", MB'(op_count - base), MB'(1));
        check("k2_seq", MB'(op_seq[0]), MB'(0));
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_scalar_mul_ctrl.md
Name: ecc_scalar_mul_ctrl

Overview:
- Sequencer for scalar point multiplication R = k·P over GF(p), MSB-first double-and-add.
- Issues DOUBLE/ADD commands to an external shared point-operation unit over a req/done handshake.
- Holds the accumulator point and handles all point-at-infinity cases locally.
- Sits between the key-exchange core (aP, a·Pb requests) and the point-op datapath.

Parameters:
- MAX_BITS, 256: width of scalar, coordinates and prime.
- IDX_W, $clog2(MAX_BITS): width of the bit-index counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_scalar  in  MAX_BITS  scalar k.
- i_px, i_py  in  MAX_BITS each  base point P (affine, never infinity).
- i_prime  in  MAX_BITS  field prime.
- o_busy  out  1  high from the cycle after an accepted start until DONE ends.
- o_done  out  1  one-cycle pulse; result valid.
- o_rx, o_ry  out  MAX_BITS each  result coordinates; held until the next o_done.
- o_inf  out  1  result is the point at infinity.
- o_op_req  out  1  point-op request.
- o_op_code  out  1  0 = DOUBLE(A), 1 = ADD(A,B).
- o_op_ax, o_op_ay, o_op_bx, o_op_by, o_op_prime  out  MAX_BITS each  registered operands.
- i_op_done  in  1  point-op completion pulse.
- i_op_rx, i_op_ry  in  MAX_BITS each  point-op result.
- i_op_inf  in  1  point-op result is infinity.

Behaviour:
- Reset: state = IDLE. All outputs = 0, including o_busy, o_done, o_op_req, o_rx, o_ry, o_inf. Internal accumulator R = infinity.
- IDLE:
  - When i_start = 1, latch k, P and prime; set R = inf and idx = MAX_BITS-1; go to EVAL.
  - i_start in any other state is ignored.
- EVAL (1 cycle per bit):
  - If R = inf: when k[idx] = 1, set R = P with no op issued. Then STEP.
  - If R != inf: go to DBL.
- DBL:
  - o_op_req = 1, code = 0, A = R.
  - On i_op_done: R = result (i_op_inf taken into account).
  - Then if k[idx] = 1: if the result is inf, set R = P and STEP; otherwise go to ADD.
  - If k[idx] = 0: STEP.
- ADD:
  - o_op_req = 1, code = 1, A = R, B = P.
  - On i_op_done: R = result, then STEP.
- STEP (combinational decision):
  - If idx = 0, go to DONE.
  - Otherwise idx decrements and the state returns to EVAL next cycle.
- DONE: o_done = 1 for exactly one cycle; o_rx/o_ry/o_inf = R; then return to IDLE.
- Handshake:
  - o_op_req rises the cycle after entering DBL/ADD.
  - o_op_req and its operands stay stable until the cycle i_op_done is sampled high.
  - o_op_req deasserts the following cycle.
  - i_op_done sampled while o_op_req = 0 is ignored.
- Latency:
  - Scalar 0: o_done in cycle MAX_BITS+1 after the start cycle, with no ops issued.
  - General case: MAX_BITS EVAL cycles, plus 1 cycle per op, plus the op wait time, plus 1 DONE cycle.
- Reset mid-operation: immediately returns to IDLE and drops o_op_req. A pending point-op result arriving afterwards is ignored.
- Inputs i_* are only sampled at start; later changes do not affect the running computation.

Optional Feature:
- Macro ECC_SMUL_CONST_TIME_EN.
- Defined:
  - After every DBL with a non-inf result, ADD is always issued.
  - When k[idx] = 0, the ADD result is discarded and R keeps the DBL result.
  - Op count depends only on the position of the leading one.
- Undefined: ADD is issued only for set bits, as described above.

Decomposition:
- Package ecc_pkg holds:
  - MAX_BITS.
  - Op-code constants OP_DBL = 1'b0 and OP_ADD = 1'b1.
  - State enum {IDLE, EVAL, DBL, ADD, DONE}.
  - A point struct {x, y, inf}, shared with the point-op unit and the key-exchange core.
- No sub-module; the point-op unit is external and shared.

Test Plan:
Bench uses a behavioural point-op model on curve y² = x³+2x+2 mod 17, P = (5,1), with a random 1–20 cycle done delay.
- k = 0 -> o_done in cycle MAX_BITS+1, o_inf = 1, zero op requests.
- k = 1 -> (o_rx, o_ry) = (5,1), o_inf = 0, zero op requests.
- k = 9 -> ops DBL, DBL, DBL, ADD in that order; result (7,6). With ECC_SMUL_CONST_TIME_EN: 6 ops, same result.
- k = 19 (group order) -> ops DBL, DBL, DBL, ADD, DBL, ADD; o_inf = 1.
- i_start pulsed while busy, and i_op_done pulsed while idle -> both ignored; operands stay stable throughout each request; result still (7,6) for k = 9.
- rst asserted during a DBL wait -> o_op_req = 0 and o_busy = 0 immediately; a late i_op_done is ignored; a subsequent k = 2 run returns (6,3).
